// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Data paths narrower than XLEN_DEFAULT are carried zero-extended in wb_req_t.
package wb_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Channel indices into the request/grant vectors.
  localparam int unsigned CH_ALU = 0;
  localparam int unsigned CH_LSU = 1;

  typedef struct packed {
    logic                    valid;
    reg_addr_t               addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_grant.sv
// Two-requester write-back grant logic. Default: LSU fixed priority with an ALU
// starvation counter; WBARB_RR_EN selects round-robin on contention.
module wb_grant
  import wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic w_contended;

  assign w_contended = i_req[CH_ALU] & i_req[CH_LSU];

`ifdef WBARB_RR_EN

  // Set when the LSU won the most recent contended cycle.
  logic r_ptr;
  logic w_ptr_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (!i_rst && w_contended) begin
      w_ptr_next = o_gnt[CH_LSU];
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (!i_rst) begin
      if (w_contended) begin
        o_gnt = r_ptr ? 2'b01 : 2'b10;
      end else begin
        o_gnt = i_req;
      end
    end
  end

`else

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] r_starve;
  logic [CntW-1:0] w_starve_next;
  logic            w_force;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_next;
    end
  end

  assign w_force = (r_starve >= CntLimit);

  // Counts consecutive cycles the ALU waits; saturates until it is served.
  always_comb begin
    w_starve_next = r_starve;
    if (!i_req[CH_ALU] || o_gnt[CH_ALU]) begin
      w_starve_next = '0;
    end else if (r_starve < CntLimit) begin
      w_starve_next = r_starve + CntW'(1);
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (!i_rst) begin
      if (w_contended) begin
        o_gnt = w_force ? 2'b01 : 2'b10;
      end else begin
        o_gnt = i_req;
      end
    end
  end

`endif

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto one register-file write port
// and tracks pending writes. Macro WBARB_RR_EN selects round-robin arbitration.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_addr,
  output logic [31:0]     busy,
  output logic            write_ena,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data
);

  logic [1:0]      w_gnt;
  wb_req_t         w_sel;
  logic            w_wr_en;
  logic [31:0]     w_busy_next;

  logic            r_wr_ena;
  reg_addr_t       r_wr_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [31:0]     r_busy;

  wb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .i_clk (clk),
    .i_rst (rst),
    .i_req ({lsu_valid, alu_valid}),
    .o_gnt (w_gnt)
  );

  assign alu_ready = w_gnt[CH_ALU];
  assign lsu_ready = w_gnt[CH_LSU];

  always_comb begin
    w_sel = '0;
    if (w_gnt[CH_ALU]) begin
      w_sel.valid = 1'b1;
      w_sel.addr  = alu_addr;
      w_sel.data  = XLEN_DEFAULT'(alu_data);
    end else if (w_gnt[CH_LSU]) begin
      w_sel.valid = 1'b1;
      w_sel.addr  = lsu_addr;
      w_sel.data  = XLEN_DEFAULT'(lsu_data);
    end
  end

  // x0 writes complete the handshake but never reach the register file.
  assign w_wr_en = w_sel.valid && (w_sel.addr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ena  <= 1'b0;
      r_wr_addr <= REG_ZERO;
      r_wr_data <= '0;
    end else begin
      r_wr_ena <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= w_sel.addr;
        r_wr_data <= w_sel.data[XLEN-1:0];
      end
    end
  end

  // Set after clear so a new reservation wins over a retiring write.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_en) begin
      w_busy_next[w_sel.addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != REG_ZERO)) begin
      w_busy_next[rsv_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy       = r_busy;
  assign write_ena  = r_wr_ena;
  assign write_addr = r_wr_addr;
  assign write_data = r_wr_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (XLEN=64, STARVE_LIMIT=3).
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [63:0] lsu_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [31:0] busy;
  logic        write_ena;
  logic [4:0]  write_addr;
  logic [63:0] write_data;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter #(
    .XLEN         (64),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .busy       (busy),
    .write_ena  (write_ena),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Contended grant sequence, 1 = LSU wins.
`ifdef WBARB_RR_EN
  bit exp_lsu[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  bit exp_lsu[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    tick();
    tick();

    // Reset state and ready gating while in reset
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_write_ena", write_ena, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b0;
    tick();

    // Sole ALU request
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'h1234;
    #1;
    check("s1_alu_ready", alu_ready, 1);
    check("s1_lsu_ready", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    check("s1_write_ena", write_ena, 1);
    check("s1_write_addr", write_addr, 5);
    check("s1_write_data", write_data, 64'h1234);
    tick();
    check("s1_pulse_end", write_ena, 0);
    check("s1_hold_addr", write_addr, 5);
    check("s1_hold_data", write_data, 64'h1234);

    // Continuous contention
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'h33;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 64'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("s2_lsu_ready_%0d", i), lsu_ready, exp_lsu[i]);
      check($sformatf("s2_alu_ready_%0d", i), alu_ready, !exp_lsu[i]);
      tick();
      check($sformatf("s2_write_addr_%0d", i), write_addr, exp_lsu[i] ? 5'd4 : 5'd3);
      check($sformatf("s2_write_data_%0d", i), write_data, exp_lsu[i] ? 64'h44 : 64'h33);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // x0 filter
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_valid = 1'b0;
    check("s3_busy_rsv9", busy, 32'h200);
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 64'hFF;
    #1;
    check("s3_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    check("s3_write_ena", write_ena, 0);
    check("s3_busy", busy, 32'h200);

    // Scoreboard set / clear / collision
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    check("s4_busy_set7", busy, 32'h280);
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'h77;
    tick();
    alu_valid = 1'b0;
    check("s4_busy_clr7", busy, 32'h200);
    check("s4_write_ena", write_ena, 1);
    check("s4_write_addr", write_addr, 7);
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'h78;
    tick();
    alu_valid = 1'b0; rsv_valid = 1'b0;
    check("s4_busy_collide", busy, 32'h280);
    check("s4_collide_data", write_data, 64'h78);
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    tick();
    rsv_valid = 1'b0;
    check("s4_rsv_x0", busy, 32'h280);

    // Build busy = 0xF00, then reset mid-operation
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'h7;
    rsv_valid = 1'b1; rsv_addr = 5'd8;
    tick();
    alu_valid = 1'b0;
    check("s5_busy_300", busy, 32'h300);
    rsv_addr = 5'd10;
    tick();
    rsv_addr = 5'd11;
    tick();
    rsv_valid = 1'b0;
    check("s5_busy_f00", busy, 32'hF00);
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 64'hCC;
    rst = 1'b1;
    #1;
    check("s5_rst_alu_ready0", alu_ready, 0);
    tick();
    check("s5_rst_busy", busy, 0);
    check("s5_rst_write_ena", write_ena, 0);
    check("s5_rst_alu_ready1", alu_ready, 0);
    tick();
    check("s5_rst_alu_ready2", alu_ready, 0);
    check("s5_rst_write_ena2", write_ena, 0);
    rst = 1'b0;
    #1;
    check("s5_post_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("s5_post_write_ena", write_ena, 1);
    check("s5_post_write_addr", write_addr, 12);
    check("s5_post_write_data", write_data, 64'hCC);
    check("s5_post_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of write-back path and register file.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive ALU wait cycles before forced ALU grant (fixed-priority mode only).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 alu_valid  input  1  ALU write-back request.
REQ-006 alu_ready  output  1  ALU request accepted this cycle.
REQ-007 alu_addr  input  5  ALU destination register.
REQ-008 alu_data  input  XLEN  ALU result.
REQ-009 lsu_valid, lsu_ready, lsu_addr, lsu_data  same directions and widths as ALU set; load-unit write-back channel.
REQ-010 rsv_valid  input  1  issue stage reserves destination register.
REQ-011 rsv_addr  input  5  register being reserved.
REQ-012 busy  output  32  per-register pending-write scoreboard.
REQ-013 write_ena  output  1  register-file write enable.
REQ-014 write_addr  output  5  register-file write address.
REQ-015 write_data  output  XLEN  register-file write data.

Function
REQ-016 Handshake: transfer on a channel SHALL occur when valid and ready are both high at posedge; ready is combinational from arbitration, independent of that channel's own data.
REQ-017 At most one channel SHALL be granted per cycle; a sole valid requester SHALL be granted the same cycle.
REQ-018 Write-back outputs SHALL be registered: a transfer at posedge N drives write_ena/addr/data during cycle N+1 only (one-cycle latency, one-cycle pulse).
REQ-019 Transfer with addr 0 SHALL complete the handshake but SHALL NOT assert write_ena (x0 filter).
REQ-020 No valid transfer in a cycle SHALL yield write_ena=0 next cycle; write_addr/write_data hold their last value.
REQ-021 Scoreboard: rsv_valid with rsv_addr!=0 SHALL set busy[rsv_addr] at posedge.
REQ-022 An accepted non-x0 transfer SHALL clear busy[addr] at the same posedge the write_ena register is loaded.
REQ-023 Simultaneous set and clear of the same register SHALL leave the bit set (new producer wins).
REQ-024 busy[0] SHALL be 0 at all times; rsv_addr 0 SHALL be ignored.
REQ-025 Holding valid with no grant SHALL be legal; inputs are sampled only at the granting edge.

Reset
REQ-026 rst at posedge SHALL clear busy to 0, write_ena to 0, write_addr/write_data to 0, starvation counter and round-robin pointer to 0.
REQ-027 While rst is high, alu_ready and lsu_ready SHALL be 0; no transfer completes, and reset mid-operation discards any in-flight write.

Configuration
REQ-028 Macro WBARB_RR_EN defined: round-robin arbitration; on contention the channel not granted last SHALL win; pointer updates only on a contended grant; STARVE_LIMIT unused.
REQ-029 Macro WBARB_RR_EN undefined: LSU has fixed priority; a counter of consecutive cycles with alu_valid high and no ALU grant SHALL, on reaching STARVE_LIMIT, force the ALU grant the next contended cycle, then reset to 0; counter also resets on any ALU grant.

Structure
REQ-030 Shared package wb_pkg SHALL hold XLEN default, reg-address typedef (5 bits), write-back request struct (valid, addr, data) and the REG_ZERO constant.
REQ-031 Arbitration logic SHALL be a sub-module wb_grant (two requests in, one-hot grant out, containing counter or pointer state); scoreboard stays in wb_arbiter.

Verification
REQ-032 Scenario: ALU only, addr 5, data 0x1234 -> alu_ready=1 same cycle; next cycle write_ena=1, write_addr=5, write_data=0x1234.
REQ-033 Scenario: both valid continuously (fixed priority, STARVE_LIMIT=3) -> grants LSU,LSU,LSU,ALU,LSU...; with WBARB_RR_EN -> strict alternation.
REQ-034 Scenario: LSU addr 0 data 0xFF -> lsu_ready=1, write_ena stays 0, busy unchanged.
REQ-035 Scenario: rsv addr 7, then ALU write addr 7 -> busy[7]=1 after rsv edge, 0 after write edge; rsv 7 and write 7 same edge -> busy[7] stays 1.
REQ-036 Scenario: rst asserted while ALU valid and busy=0x0000_0F00 -> next cycle busy=0, write_ena=0, alu_ready=0 throughout reset.
